// File: rtl/fifo_common_pkg.sv
// Helpers shared by the synchronous FIFO family: address sizing and
// pointer arithmetic on wrap-bit pointers.
package fifo_common_pkg;

  // Address width for a power-of-two depth in 4..131072.
  // Returns 0 for any other depth so the instantiating module can reject it.
  function automatic int unsigned addr_width(input int unsigned depth);
    if (depth < 4 || depth > 131072 || (depth & (depth - 1)) != 0) return 0;
    return $clog2(depth);
  endfunction

  // Distance between two pointers of aw+1 bits, including the wrap bit.
  // The subtraction is exact modulo 2^(aw+1), so no full/empty ambiguity.
  function automatic int unsigned ptr_diff(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned aw);
    return (a - b) & ((32'd1 << (aw + 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_sync_pkt_if.sv
// Write/read/status bundle of the packet FIFO. The master is the client
// logic; the slave is the FIFO itself.
interface fifo_sync_pkt_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  flush;
  logic [ADDR_WIDTH:0]   full_threshold_value;
  logic [ADDR_WIDTH:0]   empty_threshold_value;
  logic                  wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;
  logic                  wdrop;
  logic                  full;
  logic                  almost_full;
  logic                  full_threshold;
  logic                  overflow;
  logic                  pkt_err;
  logic                  ren;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  logic                  empty;
  logic                  almost_empty;
  logic                  empty_threshold;
  logic                  underflow;
  logic [ADDR_WIDTH:0]   level;
  logic [ADDR_WIDTH:0]   wr_level;

  modport master (
    output flush, full_threshold_value, empty_threshold_value,
    output wen, wdata, wlast, wdrop, ren,
    input  full, almost_full, full_threshold, overflow, pkt_err,
    input  rdata, rlast, empty, almost_empty, empty_threshold, underflow,
    input  level, wr_level
  );

  modport slave (
    input  flush, full_threshold_value, empty_threshold_value,
    input  wen, wdata, wlast, wdrop, ren,
    output full, almost_full, full_threshold, overflow, pkt_err,
    output rdata, rlast, empty, almost_empty, empty_threshold, underflow,
    output level, wr_level
  );
endinterface

// File: rtl/fifo_mem_flops.sv
// Flop-based FIFO storage: one write port, asynchronous read address,
// optional registered read data.
module fifo_mem_flops #(
  parameter int WIDTH      = 9,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int OUT_REG    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  // NOTE: the array is deliberately not reset (pointers define validity), and
  // like all sequential state it is updated with <= so readers in the same
  // edge see the old contents.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [WIDTH-1:0] rdata_d, rdata_q;

    // Load the output register only on an accepted read; hold otherwise.
    always_comb begin
      // NOTE: default first, so no path through this block leaves rdata_d
      // unassigned and infers a latch.
      rdata_d = rdata_q;
      if (re) rdata_d = mem_q[raddr];
    end

    // Output register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
  end else begin : g_fall_through
    logic unused_ok;
    assign unused_ok = &{1'b0, re, rst_n};
    assign rdata     = mem_q[raddr];
  end

endmodule

// File: rtl/fifo_sync_pkt.sv
// Synchronous FIFO with packet commit/drop on the write side, stored
// last-word marker, fill levels, thresholds and synchronous flush.
module fifo_sync_pkt
  import fifo_common_pkg::*;
#(
  parameter int pDATA_WIDTH  = 8,
  parameter int pDEPTH       = 32,
  parameter int pFALLTHROUGH = 0,
  parameter int pPACKET_MODE = 1
) (
  input logic            clk,
  input logic            rst_n,
  fifo_sync_pkt_if.slave bus
);

  localparam int unsigned pADDR_WIDTH = addr_width(pDEPTH);

  if (pADDR_WIDTH == 0) begin : g_bad_depth
    $error("fifo_sync_pkt: pDEPTH must be a power of two in 4..131072");
  end

  typedef logic [pADDR_WIDTH:0] ptr_t;

  ptr_t wptr_q, wptr_d;   // speculative write pointer
  ptr_t cptr_q, cptr_d;   // committed write pointer
  ptr_t rptr_q, rptr_d;   // read pointer
  logic pkt_err_q, pkt_err_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  ptr_t level, wr_level;
  logic full, empty, drop, rd_ok, wr_ok, err_now;
  logic [pDATA_WIDTH:0] mem_rdata;

  assign level    = ptr_t'(ptr_diff(32'(cptr_q), 32'(rptr_q), pADDR_WIDTH));
  assign wr_level = ptr_t'(ptr_diff(32'(wptr_q), 32'(rptr_q), pADDR_WIDTH));
  assign full     = (wr_level == ptr_t'(pDEPTH));
  assign empty    = (level == '0);

  // A read frees the slot the same-cycle write lands in, so a full FIFO
  // still accepts a write while a read is honoured.
  assign drop    = (pPACKET_MODE != 0) && bus.wdrop;
  assign rd_ok   = bus.ren && !empty;
  assign wr_ok   = bus.wen && !drop && (!full || rd_ok);
  assign err_now = pkt_err_q || (bus.wen && !drop && !wr_ok);

  // Pointer and flag next-state: flush, then drop, then write/commit.
  always_comb begin
    wptr_d      = wptr_q;
    cptr_d      = cptr_q;
    rptr_d      = rptr_q;
    pkt_err_d   = pkt_err_q;
    overflow_d  = bus.wen && !drop && !wr_ok;
    underflow_d = bus.ren && empty;
    if (bus.flush) begin
      wptr_d      = '0;
      cptr_d      = '0;
      rptr_d      = '0;
      pkt_err_d   = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (rd_ok) rptr_d = rptr_q + ptr_t'(1);
      if (drop) begin
        wptr_d    = cptr_q;
        pkt_err_d = 1'b0;
      end else if (bus.wen) begin
        if (wr_ok) wptr_d = wptr_q + ptr_t'(1);
        if (pPACKET_MODE == 0) begin
          if (wr_ok) cptr_d = wptr_q + ptr_t'(1);
        end else if (bus.wlast) begin
          if (err_now) begin
            // Packet lost a word: roll the whole packet back.
            wptr_d    = cptr_q;
            pkt_err_d = 1'b0;
          end else begin
            cptr_d = wptr_q + ptr_t'(1);
          end
        end else if (!wr_ok) begin
          pkt_err_d = 1'b1;
        end
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      cptr_q      <= '0;
      rptr_q      <= '0;
      pkt_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      cptr_q      <= cptr_d;
      rptr_q      <= rptr_d;
      pkt_err_q   <= pkt_err_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_flops #(
    .WIDTH      (pDATA_WIDTH + 1),
    .DEPTH      (pDEPTH),
    .ADDR_WIDTH (pADDR_WIDTH),
    .OUT_REG    ((pFALLTHROUGH != 0) ? 0 : 1)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok && !bus.flush),
    .waddr (wptr_q[pADDR_WIDTH-1:0]),
    .wdata ({bus.wlast, bus.wdata}),
    .raddr (rptr_q[pADDR_WIDTH-1:0]),
    .re    (rd_ok && !bus.flush),
    .rdata (mem_rdata)
  );

  assign bus.rdata           = mem_rdata[pDATA_WIDTH-1:0];
  assign bus.rlast           = mem_rdata[pDATA_WIDTH];
  assign bus.level           = level;
  assign bus.wr_level        = wr_level;
  assign bus.full            = full;
  assign bus.almost_full     = (wr_level >= ptr_t'(pDEPTH - 1));
  assign bus.empty           = empty;
  assign bus.almost_empty    = (level <= ptr_t'(1));
  assign bus.overflow        = overflow_q;
  assign bus.underflow       = underflow_q;
  assign bus.pkt_err         = pkt_err_q;
  // Thresholds are forced low in reset so only empty flags are high there.
  assign bus.full_threshold  = rst_n && (wr_level >= bus.full_threshold_value);
  assign bus.empty_threshold = rst_n && (level <= bus.empty_threshold_value);

endmodule

// File: tb/tb_fifo_sync_pkt.sv
// Directed bench for fifo_sync_pkt on three configurations:
//   A: depth 8, registered read, packet mode
//   B: depth 4, fall-through read, packet mode
//   C: depth 4, registered read, streaming mode
module tb_fifo_sync_pkt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  fifo_sync_pkt_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) if_a ();
  fifo_sync_pkt_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) if_b ();
  fifo_sync_pkt_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) if_c ();

  fifo_sync_pkt #(.pDATA_WIDTH(8), .pDEPTH(8), .pFALLTHROUGH(0), .pPACKET_MODE(1))
    u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  fifo_sync_pkt #(.pDATA_WIDTH(8), .pDEPTH(4), .pFALLTHROUGH(1), .pPACKET_MODE(1))
    u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  fifo_sync_pkt #(.pDATA_WIDTH(8), .pDEPTH(4), .pFALLTHROUGH(0), .pPACKET_MODE(0))
    u_dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if_a.flush = 0; if_a.wen = 0; if_a.wdata = 0; if_a.wlast = 0; if_a.wdrop = 0; if_a.ren = 0;
    if_b.flush = 0; if_b.wen = 0; if_b.wdata = 0; if_b.wlast = 0; if_b.wdrop = 0; if_b.ren = 0;
    if_c.flush = 0; if_c.wen = 0; if_c.wdata = 0; if_c.wlast = 0; if_c.wdrop = 0; if_c.ren = 0;
  endtask

  task automatic test_reset();
    logic [8:0] flags;
    if_a.full_threshold_value = 4'd0;
    if_a.empty_threshold_value = 4'd1;
    #12;
    // order: empty almost_empty empty_th full_th full almost_full overflow underflow pkt_err
    flags = {if_a.empty, if_a.almost_empty, if_a.empty_threshold, if_a.full_threshold,
             if_a.full, if_a.almost_full, if_a.overflow, if_a.underflow, if_a.pkt_err};
    n_total++; if (flags !== 9'b110000000) $display("FAIL reset_flags got=%b exp=%b", flags, 9'b110000000); else n_pass++;
    n_total++; if ({if_a.level, if_a.wr_level} !== 8'd0) $display("FAIL reset_levels got=%0d/%0d exp=0/0", if_a.level, if_a.wr_level); else n_pass++;
    n_total++; if ({if_a.rlast, if_a.rdata} !== 9'd0) $display("FAIL reset_rdata got=%h exp=0", {if_a.rlast, if_a.rdata}); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_total++; if (if_a.full_threshold !== 1'b1) $display("FAIL post_reset_full_th got=%b exp=1", if_a.full_threshold); else n_pass++;
    if_a.full_threshold_value = 4'd8;
  endtask

  task automatic test_commit();
    if_a.wen = 1; if_a.wdata = 8'hA1; if_a.wlast = 0; tick();
    n_total++; if ({if_a.empty, if_a.wr_level} !== {1'b1, 4'd1}) $display("FAIL commit_spec1 got=%b/%0d exp=1/1", if_a.empty, if_a.wr_level); else n_pass++;
    if_a.wdata = 8'hB2; tick();
    if_a.wdata = 8'hC3; if_a.wlast = 1;
    n_total++; if (if_a.empty !== 1'b1) $display("FAIL commit_empty_before got=%b exp=1", if_a.empty); else n_pass++;
    tick();
    if_a.wen = 0; if_a.wlast = 0;
    n_total++; if ({if_a.empty, if_a.level} !== {1'b0, 4'd3}) $display("FAIL commit_level got=%b/%0d exp=0/3", if_a.empty, if_a.level); else n_pass++;
    if_a.ren = 1;
    tick();
    n_total++; if ({if_a.rlast, if_a.rdata} !== {1'b0, 8'hA1}) $display("FAIL commit_rd0 got=%b/%h exp=0/a1", if_a.rlast, if_a.rdata); else n_pass++;
    tick();
    n_total++; if ({if_a.rlast, if_a.rdata} !== {1'b0, 8'hB2}) $display("FAIL commit_rd1 got=%b/%h exp=0/b2", if_a.rlast, if_a.rdata); else n_pass++;
    tick();
    if_a.ren = 0;
    n_total++; if ({if_a.rlast, if_a.rdata} !== {1'b1, 8'hC3}) $display("FAIL commit_rd2 got=%b/%h exp=1/c3", if_a.rlast, if_a.rdata); else n_pass++;
    n_total++; if ({if_a.empty, if_a.level} !== {1'b1, 4'd0}) $display("FAIL commit_drained got=%b/%0d exp=1/0", if_a.empty, if_a.level); else n_pass++;
  endtask

  task automatic test_drop();
    for (int i = 0; i < 5; i++) begin
      if_a.wen = 1; if_a.wdata = 8'h10 + 8'(i); if_a.wlast = 0; tick();
    end
    n_total++; if ({if_a.wr_level, if_a.level, if_a.empty} !== {4'd5, 4'd0, 1'b1}) $display("FAIL drop_build got=%0d/%0d/%b exp=5/0/1", if_a.wr_level, if_a.level, if_a.empty); else n_pass++;
    // Drop wins over a same-cycle committing write.
    if_a.wdata = 8'hEE; if_a.wlast = 1; if_a.wdrop = 1; tick();
    if_a.wen = 0; if_a.wlast = 0; if_a.wdrop = 0;
    n_total++; if ({if_a.wr_level, if_a.level, if_a.empty} !== {4'd0, 4'd0, 1'b1}) $display("FAIL drop_after got=%0d/%0d/%b exp=0/0/1", if_a.wr_level, if_a.level, if_a.empty); else n_pass++;
    if_a.ren = 1; tick();
    if_a.ren = 0;
    n_total++; if (if_a.underflow !== 1'b1) $display("FAIL drop_underflow got=%b exp=1", if_a.underflow); else n_pass++;
    n_total++; if ({if_a.rlast, if_a.rdata} !== {1'b1, 8'hC3}) $display("FAIL drop_rdata_hold got=%b/%h exp=1/c3", if_a.rlast, if_a.rdata); else n_pass++;
    tick();
    n_total++; if (if_a.underflow !== 1'b0) $display("FAIL drop_underflow_pulse got=%b exp=0", if_a.underflow); else n_pass++;
  endtask

  task automatic test_thresholds();
    logic exp_ft, exp_et;
    if_a.full_threshold_value = 4'd3;
    if_a.empty_threshold_value = 4'd1;
    for (int i = 0; i < 3; i++) begin
      if_a.wen = 1; if_a.wdata = 8'h30 + 8'(i); if_a.wlast = 1; tick();
      exp_ft = (i + 1 >= 3);
      exp_et = (i + 1 <= 1);
      n_total++; if ({if_a.full_threshold, if_a.empty_threshold} !== {exp_ft, exp_et}) $display("FAIL thr_fill%0d got=%b%b exp=%b%b", i, if_a.full_threshold, if_a.empty_threshold, exp_ft, exp_et); else n_pass++;
    end
    if_a.wen = 0; if_a.wlast = 0; if_a.ren = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_et = (2 - k <= 1);
      n_total++; if ({if_a.rdata, if_a.empty_threshold, if_a.full_threshold} !== {8'h30 + 8'(k), exp_et, 1'b0}) $display("FAIL thr_drain%0d got=%h/%b/%b exp=%h/%b/0", k, if_a.rdata, if_a.empty_threshold, if_a.full_threshold, 8'h30 + 8'(k), exp_et); else n_pass++;
    end
    if_a.ren = 0;
    if_a.full_threshold_value = 4'd8;
  endtask

  task automatic test_flush();
    if_a.wen = 1; if_a.wdata = 8'h51; if_a.wlast = 0; tick();
    if_a.wdata = 8'h52; if_a.wlast = 1; tick();
    if_a.wdata = 8'h53; if_a.wlast = 0; tick();
    if_a.wen = 0;
    n_total++; if ({if_a.level, if_a.wr_level} !== {4'd2, 4'd3}) $display("FAIL flush_pre got=%0d/%0d exp=2/3", if_a.level, if_a.wr_level); else n_pass++;
    if_a.flush = 1; tick();
    if_a.flush = 0;
    n_total++; if ({if_a.level, if_a.wr_level, if_a.empty} !== {4'd0, 4'd0, 1'b1}) $display("FAIL flush_levels got=%0d/%0d/%b exp=0/0/1", if_a.level, if_a.wr_level, if_a.empty); else n_pass++;
    n_total++; if (if_a.rdata !== 8'h32) $display("FAIL flush_rdata_hold got=%h exp=32", if_a.rdata); else n_pass++;
    if_a.wen = 1; if_a.wdata = 8'h61; if_a.wlast = 1; tick();
    if_a.wen = 0; if_a.wlast = 0; if_a.ren = 1; tick();
    if_a.ren = 0;
    n_total++; if ({if_a.rdata, if_a.level} !== {8'h61, 4'd0}) $display("FAIL flush_reuse got=%h/%0d exp=61/0", if_a.rdata, if_a.level); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      if_b.wen = 1; if_b.wdata = 8'h40 + 8'(i); if_b.wlast = (i == 5); tick();
      if (i == 2) begin
        n_total++; if ({if_b.almost_full, if_b.full} !== 2'b10) $display("FAIL ovf_almost got=%b%b exp=10", if_b.almost_full, if_b.full); else n_pass++;
      end
      if (i == 3) begin
        n_total++; if ({if_b.full, if_b.wr_level, if_b.overflow} !== {1'b1, 3'd4, 1'b0}) $display("FAIL ovf_full got=%b/%0d/%b exp=1/4/0", if_b.full, if_b.wr_level, if_b.overflow); else n_pass++;
      end
      if (i == 4) begin
        n_total++; if ({if_b.overflow, if_b.pkt_err} !== 2'b11) $display("FAIL ovf_word5 got=%b%b exp=11", if_b.overflow, if_b.pkt_err); else n_pass++;
      end
      if (i == 5) begin
        n_total++; if ({if_b.overflow, if_b.pkt_err, if_b.wr_level, if_b.level} !== {2'b10, 3'd0, 3'd0}) $display("FAIL ovf_rollback got=%b%b/%0d/%0d exp=10/0/0", if_b.overflow, if_b.pkt_err, if_b.wr_level, if_b.level); else n_pass++;
      end
    end
    if_b.wen = 0; if_b.wlast = 0; tick();
    n_total++; if ({if_b.overflow, if_b.full, if_b.empty} !== 3'b001) $display("FAIL ovf_idle got=%b%b%b exp=001", if_b.overflow, if_b.full, if_b.empty); else n_pass++;
  endtask

  task automatic test_full_rw();
    logic [8:0] exp_q [4];
    exp_q[0] = {1'b0, 8'h71}; exp_q[1] = {1'b0, 8'h72};
    exp_q[2] = {1'b1, 8'h73}; exp_q[3] = {1'b1, 8'h74};
    for (int i = 0; i < 4; i++) begin
      if_b.wen = 1; if_b.wdata = 8'h70 + 8'(i); if_b.wlast = (i == 3); tick();
    end
    n_total++; if ({if_b.level, if_b.full, if_b.rlast, if_b.rdata} !== {3'd4, 1'b1, 1'b0, 8'h70}) $display("FAIL rw_full got=%0d/%b/%b/%h exp=4/1/0/70", if_b.level, if_b.full, if_b.rlast, if_b.rdata); else n_pass++;
    if_b.ren = 1; if_b.wdata = 8'h74; if_b.wlast = 1; tick();
    if_b.wen = 0; if_b.wlast = 0;
    n_total++; if ({if_b.overflow, if_b.level, if_b.full} !== {1'b0, 3'd4, 1'b1}) $display("FAIL rw_same_cycle got=%b/%0d/%b exp=0/4/1", if_b.overflow, if_b.level, if_b.full); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++; if ({if_b.rlast, if_b.rdata} !== exp_q[k]) $display("FAIL rw_drain%0d got=%h exp=%h", k, {if_b.rlast, if_b.rdata}, exp_q[k]); else n_pass++;
      tick();
    end
    n_total++; if ({if_b.empty, if_b.underflow} !== 2'b10) $display("FAIL rw_empty got=%b%b exp=10", if_b.empty, if_b.underflow); else n_pass++;
    tick();
    if_b.ren = 0;
    n_total++; if (if_b.underflow !== 1'b1) $display("FAIL rw_underflow got=%b exp=1", if_b.underflow); else n_pass++;
  endtask

  task automatic test_mode0();
    logic [2:0] exp_lvl;
    if_c.wen = 1; if_c.wdata = 8'h81; tick();
    n_total++; if ({if_c.level, if_c.empty} !== {3'd1, 1'b0}) $display("FAIL m0_visible got=%0d/%b exp=1/0", if_c.level, if_c.empty); else n_pass++;
    if_c.wdata = 8'h82; if_c.wdrop = 1; tick();
    if_c.wen = 0; if_c.wdrop = 0;
    n_total++; if ({if_c.level, if_c.wr_level, if_c.pkt_err} !== {3'd2, 3'd2, 1'b0}) $display("FAIL m0_drop_ignored got=%0d/%0d/%b exp=2/2/0", if_c.level, if_c.wr_level, if_c.pkt_err); else n_pass++;
    if_c.flush = 1; tick();
    if_c.flush = 0;
    n_total++; if ({if_c.level, if_c.wr_level, if_c.empty} !== {3'd0, 3'd0, 1'b1}) $display("FAIL m0_flush got=%0d/%0d/%b exp=0/0/1", if_c.level, if_c.wr_level, if_c.empty); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if_c.wen = 1; if_c.wdata = 8'h90 + 8'(i); if_c.wlast = (i == 0); tick();
      exp_lvl = (i < 4) ? 3'(i + 1) : 3'd4;
      n_total++; if ({if_c.level, if_c.overflow, if_c.pkt_err} !== {exp_lvl, (i == 4), 1'b0}) $display("FAIL m0_fill%0d got=%0d/%b/%b exp=%0d/%b/0", i, if_c.level, if_c.overflow, if_c.pkt_err, exp_lvl, (i == 4)); else n_pass++;
    end
    if_c.wen = 0; if_c.wlast = 0; if_c.ren = 1; tick();
    if_c.ren = 0;
    n_total++; if ({if_c.rlast, if_c.rdata, if_c.level} !== {1'b1, 8'h90, 3'd3}) $display("FAIL m0_read got=%b/%h/%0d exp=1/90/3", if_c.rlast, if_c.rdata, if_c.level); else n_pass++;
  endtask

  initial begin
    idle_all();
    if_b.full_threshold_value = 3'd4; if_b.empty_threshold_value = 3'd0;
    if_c.full_threshold_value = 3'd4; if_c.empty_threshold_value = 3'd0;
    test_reset();
    test_commit();
    test_drop();
    test_thresholds();
    test_flush();
    test_overflow();
    test_full_rw();
    test_mode0();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_sync_pkt.md
Name: fifo_sync_pkt

Overview:
- Parametrised synchronous single-clock FIFO, successor to the basic sync FIFO.
- Adds packet mode: the write side builds a packet speculatively, then commits or drops it as a unit.
- Also adds a stored last-word marker, fill-level outputs, synchronous flush and full-width thresholds.
- Used in front of USB/streaming readout paths, where partial or failed captures must never become visible to the reader.

Parameters:
- pDATA_WIDTH, 8: payload bits per word.
- pDEPTH, 32: entries; power of two, 4..131072. pADDR_WIDTH = log2(pDEPTH).
- pFALLTHROUGH, 0: 1 = first-word-fall-through read; 0 = registered read.
- pPACKET_MODE, 1: 1 = commit/drop semantics; 0 = every accepted write is immediately visible.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous clear of all pointers and flags
- full_threshold_value  in  pADDR_WIDTH+1  full_threshold trip level
- empty_threshold_value  in  pADDR_WIDTH+1  empty_threshold trip level
- wen  in  1  write request
- wdata  in  pDATA_WIDTH  write data
- wlast  in  1  qualifies wen: last word of packet, commit
- wdrop  in  1  discard the uncommitted packet
- full  out  1  no free entry (speculative pointer)
- almost_full  out  1  at most one free entry
- full_threshold  out  1  wr_level >= full_threshold_value
- overflow  out  1  one-cycle pulse: wen while full
- pkt_err  out  1  sticky: current packet lost a word
- ren  in  1  read request
- rdata  out  pDATA_WIDTH  read data
- rlast  out  1  marker stored with rdata
- empty  out  1  no committed word
- almost_empty  out  1  at most one committed word
- empty_threshold  out  1  level <= empty_threshold_value
- underflow  out  1  one-cycle pulse: ren while empty
- level  out  pADDR_WIDTH+1  committed words readable
- wr_level  out  pADDR_WIDTH+1  committed + uncommitted words

Behaviour:
- Pointers are pADDR_WIDTH+1 bits, modulo 2^(pADDR_WIDTH+1):
  - wptr: speculative write pointer.
  - cptr: committed write pointer.
  - rptr: read pointer.
  - Reset and flush set all three to 0.
  - Storage holds {wlast, wdata} per entry and is not cleared.
- level = cptr - rptr; wr_level = wptr - rptr.
- empty = level==0; almost_empty = level<=1; full = wr_level==pDEPTH; almost_full = wr_level>=pDEPTH-1.
- Write:
  - wen && !full: store at wptr, wptr+1.
  - If also wlast and !pkt_err: cptr <= wptr+1. The word is readable the next cycle; write-to-empty-deassert latency is 1.
- Error:
  - wen && full: word discarded, overflow=1 next cycle, pkt_err set.
  - Any wlast (accepted or not) with pkt_err set or being set: wptr <= cptr (packet rolled back), pkt_err cleared.
- Drop: wdrop has priority over a same-cycle wen. Effect: wptr <= cptr, pkt_err cleared, the write is ignored.
- pPACKET_MODE=0:
  - cptr follows wptr on every accepted write.
  - wlast is still stored; wdrop is ignored.
  - pkt_err is held at 0; overflow still pulses.
- Read:
  - ren && !empty: rptr+1.
  - pFALLTHROUGH=1: rdata/rlast = mem[rptr] combinationally; valid whenever !empty.
  - pFALLTHROUGH=0: rdata/rlast register mem[rptr] on ren && !empty; they hold otherwise. Reset value 0; flush does not clear them.
  - ren && empty: underflow=1 next cycle; no pointer change.
- Simultaneous events:
  - Read and write in the same cycle are both honoured, including when full, since full is evaluated before the read.
  - Commit and read in the same cycle: level = old level + committed words - 1.
- Thresholds are pure compares on level/wr_level; no wrap tricks, since pointer differences are exact.
- Priority: rst_n > flush > wdrop > write/commit. Flush clears pkt_err, overflow and underflow.
- Reset mid-packet loses the packet entirely. All outputs are 0 during reset except empty=1 and almost_empty=1.

Decomposition:
- Shared package fifo_common_pkg holds:
  - the address-width constant function (log2, with a range check that errors on a non-power-of-two pDEPTH);
  - the pointer-difference helper shared with the existing sync FIFO.
- One sub-module, fifo_mem_flops: an {1+pDATA_WIDTH}-wide flop array with write port, asynchronous read address and optional output register. The top keeps pointers, flags and packet control.

Test Plan:
- Write 3 words (A,B,C), wlast on C -> empty stays 1 until the cycle after C; then level=3, and reading gives A,B,C with rlast only on C.
- Write 5 words, then assert wdrop -> wr_level returns 0, level stays 0, empty stays 1, and no read data appears.
- pDEPTH=4: write 6 words with wlast on word 6 -> full after 4, overflow pulses on words 5 and 6, pkt_err=1, then rollback gives wr_level=0 and pkt_err=0.
- FIFO full (4 committed), ren and wen+wlast in the same cycle -> read succeeds, the new word is accepted and committed, level stays 4.
- Thresholds full_threshold_value=3, empty_threshold_value=1 -> full_threshold rises at wr_level 3; empty_threshold falls when level reaches 2.
- flush mid-packet with level=2, then pPACKET_MODE=0 rerun -> all levels 0, flags cleared; in mode 0 each write is readable the next cycle.
